seg7_scan_controller: RTL
=========================

// Module: seg7_scan_controller
// PURPOSE
//  Time-multiplexed 4-digit 7-segment display scanner for the Basys3 board.
//  Drives the 2-bit select of the upstream 4-way nibble multiplexer and
//  consumes the nibble it returns. Decodes that nibble to active-low segments
//  with optional leading-zero blanking, and drives the active-low anodes.
//  Sits between the mouse-driver status registers/mux and the board pins.
// PARAMETERS
//  CLK_HZ      100_000_000  system clock frequency (Hz)
//  REFRESH_HZ  1000         per-digit refresh rate (Hz); whole frame = REFRESH_HZ/4
//  BLANK_LZ    1            1 = blank leading zeros on digits 3..1; 0 = show all
// PORTS
//  CLK         in   1  system clock; all logic on rising edge
//  RESET       in   1  synchronous reset, active-high
//  ENABLE      in   1  1 = scan; 0 = display dark, prescaler held
//  DIGIT_IN    in   4  nibble from the mux, selected by MUX_SEL
//  DP_MASK     in   4  decimal point per digit, 1 = lit (bit n -> digit n)
//  MUX_SEL     out  2  digit index to the mux select input
//  SEG_SELECT  out  4  anodes, active-low, one-hot-low when lit
//  HEX_OUT     out  8  {dp, g,f,e,d,c,b,a}, active-low
//  DIGIT_TICK  out  1  1-cycle pulse when MUX_SEL advances
// BEHAVIOUR
//  Reset values:
//   - prescaler = 0; MUX_SEL = 2'b11; SEG_SELECT = 4'b1111; HEX_OUT = 8'hFF
//   - DIGIT_TICK = 0; nonzero_seen = 0
//  Prescaler:
//   - DIV = CLK_HZ/REFRESH_HZ - 1; counter width $clog2(DIV+1)
//   - counts 0..DIV; at DIV it wraps to 0 and DIGIT_TICK = 1 for that cycle
//  Scan order is descending, 3 -> 2 -> 1 -> 0 -> 3 (MSB first):
//   - on each tick MUX_SEL <= MUX_SEL - 1, mod 4 wrap 0 -> 3
//  Latency and pipeline:
//   - DIGIT_IN is combinational from MUX_SEL and is sampled the cycle after the tick
//   - in that cycle SEG_SELECT and HEX_OUT update together from the registered
//     sel_d (copy of MUX_SEL)
//   - SEG_SELECT/HEX_OUT therefore lag MUX_SEL by exactly 1 cycle
//   - the anode and its segment pattern never change in different cycles (no ghosting)
//   - SEG_SELECT = ~(4'b0001 << sel_d)
//  Leading-zero blanking (BLANK_LZ = 1):
//   - while sel_d == 3, nonzero_seen is cleared at start of frame
//   - digit blanked (HEX_OUT = 8'hFF except dp) iff sel_d != 0 && DIGIT_IN == 0 && !nonzero_seen
//   - nonzero_seen <= 1 when DIGIT_IN != 0; held until next frame start
//   - digit 0 is never blanked; DP still honours DP_MASK on blanked digits
//  Decode table (active-low {g..a}):
//   - 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8
//   - 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E
//   - HEX_OUT[7] = ~DP_MASK[sel_d]
//  ENABLE low:
//   - prescaler and MUX_SEL hold; no ticks
//   - next cycle SEG_SELECT = 4'b1111, HEX_OUT = 8'hFF
//  ENABLE re-asserted: scan resumes from held count and digit; no reset of the frame
//  RESET mid-scan: all state returns to reset values next edge; it overrides ENABLE
//  DIV = 0 (REFRESH_HZ = CLK_HZ): tick every cycle; still legal
// STRUCTURE
//  Package seg7_pkg:
//   - ANODES_OFF = 4'b1111, SEG_BLANK = 8'hFF
//   - 16-entry segment table / function hex_to_seg(nibble) -> 7 bits
//  Sub-module seg7_decoder: combinational nibble + dp + blank -> HEX_OUT value;
//   top holds prescaler, digit counter, sel_d pipeline and blanking flag
// TESTING (CLK_HZ=100, REFRESH_HZ=10 -> DIV=9; mux model in bench)
//  1 Reset: RESET=1 two cycles -> SEG_SELECT=F, HEX_OUT=FF, MUX_SEL=3, DIGIT_TICK=0
//  2 Scan: digits 3..0 = 1,2,3,4, ENABLE=1 -> tick every 10 cycles, MUX_SEL 3,2,1,0,3;
//    SEG_SELECT 7,B,D,E one cycle after each tick
//    HEX_OUT F9,A4,B0,99 aligned with anodes
//  3 Blanking: digits 0,0,7,0 -> digits 3,2 HEX_OUT=FF; digit1=F8; digit0=C0.
//    Digits all 0 -> only digit0 shows C0. Repeat with BLANK_LZ=0 -> all C0
//  4 DP: DP_MASK=4'b0100 on blanked digit 2 -> HEX_OUT=7F on digit2 only
//  5 ENABLE drop for 25 cycles mid-digit -> outputs FF/F next cycle, no ticks;
//    re-enable -> next tick lands after the remaining count
//  6 RESET during digit 1 with ENABLE=1 -> next cycle reset values; first tick
//    10 cycles after release, MUX_SEL 3->2

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and the hex-to-segment table for the 4-digit
// 7-segment scanner (all segment values are active-low).
package seg7_pkg;

  localparam logic [3:0] ANODES_OFF = 4'b1111;
  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam logic [1:0] SEL_FIRST  = 2'd3;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan_controller_decoder.sv
// Combinational nibble/dp/blank to active-low {dp,g..a} pattern.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  // Blanked digits keep their decimal point so the mask stays visible.
  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = {~dp, SEG_OFF};
    end else begin
      seg = {~dp, hex_to_seg(nibble)};
    end
  end

endmodule

// File: rtl/seg7_scan_controller.sv
// Time-multiplexed 4-digit 7-segment scanner: prescaler, descending digit
// counter, leading-zero blanking and registered anode/segment outputs.
module seg7_scan_controller
  import seg7_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int BLANK_LZ   = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic [3:0] DIGIT_IN,
  input  logic [3:0] DP_MASK,
  output logic [1:0] MUX_SEL,
  output logic [3:0] SEG_SELECT,
  output logic [7:0] HEX_OUT,
  output logic       DIGIT_TICK
);

  localparam int DIV = CLK_HZ / REFRESH_HZ - 1;
  localparam int CNT_W = (DIV > 0) ? $clog2(DIV + 1) : 1;
  localparam logic [CNT_W-1:0] DIV_C = CNT_W'(DIV);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam bit BLANK_EN = (BLANK_LZ != 0);

  logic [CNT_W-1:0] count_r;
  logic             nonzero_seen_r;
  logic             tick_s;
  logic             seen_s;
  logic             digit_zero_s;
  logic             blank_s;
  logic [3:0]       anode_s;
  logic [7:0]       hex_s;

  // Tick, blanking decision and anode pattern for the digit now on MUX_SEL.
  always_comb begin
    tick_s       = ENABLE && (count_r == DIV_C);
    digit_zero_s = (DIGIT_IN == 4'd0);
    seen_s       = 1'b0;
    if (MUX_SEL == SEL_FIRST) begin
      seen_s = 1'b0;
    end else begin
      seen_s = nonzero_seen_r;
    end
    blank_s = BLANK_EN && (MUX_SEL != 2'd0) && digit_zero_s && !seen_s;
    anode_s = ~(4'b0001 << MUX_SEL);
  end

  seg7_decoder u_decoder (
    .nibble (DIGIT_IN),
    .dp     (DP_MASK[MUX_SEL]),
    .blank  (blank_s),
    .seg    (hex_s)
  );

  // Prescaler and descending digit counter; both freeze while disabled.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_r    <= '0;
      MUX_SEL    <= SEL_FIRST;
      DIGIT_TICK <= 1'b0;
    end else if (ENABLE) begin
      if (tick_s) begin
        count_r <= '0;
        MUX_SEL <= MUX_SEL - 2'd1;
      end else begin
        count_r <= count_r + CNT_ONE;
        MUX_SEL <= MUX_SEL;
      end
      DIGIT_TICK <= tick_s;
    end else begin
      count_r    <= count_r;
      MUX_SEL    <= MUX_SEL;
      DIGIT_TICK <= 1'b0;
    end
  end

  // Anode and segments load on the same edge so a digit never ghosts.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      SEG_SELECT     <= ANODES_OFF;
      HEX_OUT        <= SEG_BLANK;
      nonzero_seen_r <= 1'b0;
    end else if (ENABLE) begin
      SEG_SELECT     <= anode_s;
      HEX_OUT        <= hex_s;
      nonzero_seen_r <= seen_s || !digit_zero_s;
    end else begin
      SEG_SELECT     <= ANODES_OFF;
      HEX_OUT        <= SEG_BLANK;
      nonzero_seen_r <= nonzero_seen_r;
    end
  end

endmodule
